cpu_mdu_issue: RTL and testbench

Issue and writeback sequencer for the multiply/divide unit. It accepts one M-extension request from the decode/execute stage and pulses `start` to the MDU. It then holds the operands stable, waits for the MDU `ready` pulse, and presents the result to the register-file writeback port. It also handles pipeline flushes, x0 destinations, and a watchdog against a hung MDU.

---
 rtl/cpu_mdu_pkg.sv | 27 ++
 rtl/cpu_mdu_issue.sv | 140 ++++++++++++++
 tb/tb_cpu_mdu_issue.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mdu_pkg.sv
// cpu_mdu_pkg
//   Shared definitions for the multiply/divide issue path:
//   - mdu_op_e : 3-bit M-extension op encodings, common to the decoder,
//                this sequencer and the MDU datapath
//   - state_e  : issue/writeback sequencer states
package cpu_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_mdu_issue.sv
// cpu_mdu_issue
//   Issue and writeback sequencer for the multiply/divide unit. Accepts one
//   request, pulses mdu_start, holds the operands stable, waits for
//   mdu_ready and presents the result on the register-file writeback port.
//   Handles pipeline flush, x0 destinations and a watchdog against a hung MDU.
//
//   Ports
//     clk, reset_n          clock (rising edge), async active-low reset
//     flush                 kill the in-flight request
//     req_valid/req_ready   request handshake; req_op/req_a/req_b/req_rd payload
//     mdu_start             one-cycle start pulse to the MDU
//     mdu_control           op code to the MDU
//     mdu_operand_a/_b      operands to the MDU (held until the next accept)
//     mdu_result/mdu_ready  MDU result, valid in the mdu_ready pulse cycle
//     wb_valid/wb_ack       writeback handshake; wb_rd/wb_data payload
//     busy                  sequencer not idle (pipeline stall)
//     err_timeout           one-cycle pulse when the watchdog fires
module cpu_mdu_issue
  import cpu_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  output logic            mdu_start,
  output logic [2:0]      mdu_control,
  output logic [XLEN-1:0] mdu_operand_a,
  output logic [XLEN-1:0] mdu_operand_b,
  input  logic [XLEN-1:0] mdu_result,
  input  logic            mdu_ready,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ack,
  output logic            busy,
  output logic            err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  mdu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, data_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   wd_q;
  logic            err_q;
  logic            accept;
  logic            waiting;
  logic            wd_expired;

  assign accept     = req_valid && req_ready;
  assign waiting    = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  // Fires in the TIMEOUT-th cycle spent waiting; a ready in that cycle wins.
  assign wd_expired = waiting && !mdu_ready && (wd_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (mdu_ready) begin
          if (flush || (rd_q == 5'd0)) state_d = ST_IDLE;
          else                         state_d = ST_WB;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WB:    if (wb_ack || flush) state_d = ST_IDLE;
      ST_DRAIN: if (mdu_ready || wd_expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Capture register: drives the MDU inputs in every state and only
  // changes on accept, so the MDU never sees operands move mid-operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= MDU_MUL;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= mdu_op_e'(req_op);
      a_q  <= req_a;
      b_q  <= req_b;
      rd_q <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                         data_q <= '0;
    else if ((state_q == ST_WAIT) && mdu_ready && !flush) data_q <= mdu_result;
  end

  // Watchdog: cleared on entry to WAIT (from ISSUE) and on entry to DRAIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wd_q <= '0;
    end else if ((state_q == ST_WAIT) && flush && !mdu_ready) begin
      wd_q <= '0;
    end else if (waiting) begin
      wd_q <= wd_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= wd_expired;
  end

  assign req_ready     = (state_q == ST_IDLE) && !flush;
  assign mdu_start     = (state_q == ST_ISSUE);
  assign wb_valid      = (state_q == ST_WB);
  assign busy          = (state_q != ST_IDLE);
  assign err_timeout   = err_q;
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign mdu_control   = op_q;
  assign mdu_operand_a = a_q;
  assign mdu_operand_b = b_q;

endmodule

// File: tb/tb_cpu_mdu_issue.sv
// tb_cpu_mdu_issue
//   Self-checking bench for cpu_mdu_issue. A behavioural MDU model computes
//   RV32M results with plain 64-bit arithmetic after a programmable latency;
//   scenario tasks check handshake timing, flush/x0/watchdog behaviour and
//   bit-exact result pass-through against the ISA definition.
module tb_cpu_mdu_issue;
  import cpu_mdu_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n, flush, req_valid, req_ready, wb_ack;
  logic [2:0]  req_op, mdu_control;
  logic [31:0] req_a, req_b, mdu_operand_a, mdu_operand_b, mdu_result, wb_data;
  logic [4:0]  req_rd, wb_rd;
  logic        mdu_start, mdu_ready, wb_valid, busy, err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // MDU model controls and statistics
  int          lat   = 4;
  bit          never = 1'b0;
  int          ready_cyc = -1;
  int          start_cnt = 0;
  int          err_cnt   = 0;
  int          hold_checks = 0;
  int          hold_errs   = 0;
  bit          pending = 1'b0;
  int          rem;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;

  cpu_mdu_issue #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .mdu_start(mdu_start), .mdu_control(mdu_control),
    .mdu_operand_a(mdu_operand_a), .mdu_operand_b(mdu_operand_b),
    .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M reference semantics
  function automatic logic [31:0] isa(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;           r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural MDU: ready arrives lat cycles after the start cycle.
  always @(negedge clk) begin
    mdu_ready  = 1'b0;
    mdu_result = $urandom;
    if (!reset_n) begin
      pending = 1'b0;
    end else begin
      if (mdu_start) start_cnt++;
      if (err_timeout) err_cnt++;
      if (pending) begin
        hold_checks++;
        if (mdu_control !== m_op || mdu_operand_a !== m_a || mdu_operand_b !== m_b) hold_errs++;
        rem--;
        if (rem == 0) begin
          pending    = 1'b0;
          mdu_ready  = 1'b1;
          mdu_result = isa(m_op, m_a, m_b);
          ready_cyc  = cyc;
        end
      end
      if (mdu_start && !never) begin
        pending = 1'b1;
        rem     = lat;
        m_op    = mdu_control;
        m_a     = mdu_operand_a;
        m_b     = mdu_operand_b;
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    run_cycles(1);
    req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic wait_wb(input int bound, output bit got, output bit busy_ok);
    got = 1'b0; busy_ok = 1'b1;
    for (int k = 0; k < bound; k++) begin
      if (wb_valid === 1'b1) begin got = 1'b1; break; end
      if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 1'b0;
      run_cycles(1);
    end
  endtask

  task automatic wait_idle(input int bound, output bit got, output bit wb_seen, output bit rr_ok);
    got = 1'b0; wb_seen = 1'b0; rr_ok = 1'b1;
    for (int k = 0; k < bound; k++) begin
      if (busy === 1'b0) begin got = 1'b1; break; end
      if (wb_valid !== 1'b0) wb_seen = 1'b1;
      if (req_ready !== 1'b0) rr_ok = 1'b0;
      run_cycles(1);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    tests++;
    if ({req_ready, mdu_start, wb_valid, busy, err_timeout} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, mdu_start, wb_valid, busy, err_timeout});
    end
    tests++;
    if ({wb_rd, wb_data, mdu_control, mdu_operand_a, mdu_operand_b} !== '0) begin
      fails++; $display("FAIL reset_data: wb_rd=%h wb_data=%h ctl=%h a=%h b=%h expected all zero",
                        wb_rd, wb_data, mdu_control, mdu_operand_a, mdu_operand_b);
    end
    req_valid = 1'b1;
    run_cycles(2);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_ignores_req: busy=%b expected 0", busy); end
    req_valid = 1'b0;
    reset_n = 1'b1;
    run_cycles(1);
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_idle: busy=%b req_ready=%b expected 0/1", busy, req_ready);
    end
  endtask

  task automatic test_mul();
    bit got, bok;
    int ci, s0;
    lat = 34; s0 = start_cnt;
    issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    ci = cyc;
    tests++;
    if (mdu_start !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL mul_issue: start=%b busy=%b req_ready=%b expected 1/1/0", mdu_start, busy, req_ready);
    end
    wait_wb(100, got, bok);
    tests++;
    if (!got || !bok) begin fails++; $display("FAIL mul_wait: got_wb=%0d busy_ok=%0d expected 1/1", got, bok); end
    tests++;
    if (cyc != ready_cyc + 1 || cyc != ci + lat + 1) begin
      fails++; $display("FAIL mul_latency: wb cycle %0d expected %0d (ready %0d)", cyc, ci + lat + 1, ready_cyc);
    end
    tests++;
    if (wb_rd !== 5'd5 || wb_data !== 32'hFFFF_FFEB || busy !== 1'b1) begin
      fails++; $display("FAIL mul_wb: rd=%0d data=%h busy=%b expected 5/ffffffeb/1", wb_rd, wb_data, busy);
    end
    tests++;
    if (start_cnt - s0 != 1) begin fails++; $display("FAIL mul_start_count: got %0d expected 1", start_cnt - s0); end
    wb_ack = 1'b1;
    run_cycles(1);
    wb_ack = 1'b0;
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL mul_idle: busy=%b req_ready=%b wb_valid=%b expected 0/1/0", busy, req_ready, wb_valid);
    end
  endtask

  task automatic test_div_hold();
    bit got, bok, stable;
    lat = 34;
    issue(MDU_DIV, 32'h8000_0000, 32'd0, 5'd7);
    wait_wb(100, got, bok);
    tests++;
    if (!got || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd7) begin
      fails++; $display("FAIL div0_wb: got=%0d data=%h rd=%0d expected 1/ffffffff/7", got, wb_data, wb_rd);
    end
    stable = 1'b1;
    repeat (3) begin
      run_cycles(1);
      if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd7) stable = 1'b0;
    end
    tests++;
    if (!stable) begin fails++; $display("FAIL div0_hold: wb not stable while ack low (valid=%b data=%h)", wb_valid, wb_data); end
    wb_ack = 1'b1;
    run_cycles(1);
    wb_ack = 1'b0;
    tests++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL div0_idle: busy=%b wb_valid=%b expected 0/0", busy, wb_valid);
    end
  endtask

  task automatic test_flush_drain();
    bit got, wbs, rrok;
    int ci;
    lat = 20;
    issue(MDU_MUL, $urandom, $urandom, 5'd12);
    ci = cyc;
    run_cycles(5);
    flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b1 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL flush_to_drain: busy=%b wb_valid=%b expected 1/0", busy, wb_valid);
    end
    wait_idle(100, got, wbs, rrok);
    tests++;
    if (!got || wbs || !rrok) begin
      fails++; $display("FAIL drain: idle=%0d wb_seen=%0d req_ready_low=%0d expected 1/0/1", got, wbs, rrok);
    end
    tests++;
    if (cyc != ready_cyc + 1 || cyc != ci + lat + 1) begin
      fails++; $display("FAIL drain_exit: idle cycle %0d expected %0d", cyc, ci + lat + 1);
    end
  endtask

  task automatic test_rd0();
    bit got, wbs, rrok;
    int ci, s0;
    lat = 12; s0 = start_cnt;
    issue(MDU_REMU, 32'd10, 32'd3, 5'd0);
    ci = cyc;
    wait_idle(100, got, wbs, rrok);
    tests++;
    if (!got || wbs || start_cnt - s0 != 1) begin
      fails++; $display("FAIL rd0: idle=%0d wb_seen=%0d starts=%0d expected 1/0/1", got, wbs, start_cnt - s0);
    end
    tests++;
    if (cyc != ci + lat + 1) begin fails++; $display("FAIL rd0_exit: idle cycle %0d expected %0d", cyc, ci + lat + 1); end
  endtask

  task automatic test_flush_corners();
    bit got, wbs, rrok, bok;
    int ci;
    // flush during ISSUE: start already sent, result must be drained
    lat = 8;
    issue(MDU_MULHU, $urandom, $urandom, 5'd4);
    ci = cyc;
    flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    wait_idle(100, got, wbs, rrok);
    tests++;
    if (!got || wbs || cyc != ci + lat + 1) begin
      fails++; $display("FAIL flush_issue: idle=%0d wb_seen=%0d cycle %0d expected 1/0/%0d", got, wbs, cyc, ci + lat + 1);
    end
    // flush in the same cycle as mdu_ready: result discarded
    lat = 10;
    issue(MDU_DIVU, $urandom, $urandom, 5'd6);
    run_cycles(lat);
    flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL flush_with_ready: busy=%b wb_valid=%b expected 0/0", busy, wb_valid);
    end
    // flush while idle blocks acceptance
    flush = 1'b1; req_valid = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_ready: req_ready=%b expected 0", req_ready); end
    run_cycles(1);
    flush = 1'b0; req_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle_accept: busy=%b expected 0", busy); end
    // ack and flush together in WB
    lat = 5;
    issue(MDU_MUL, 32'd3, 32'd4, 5'd8);
    wait_wb(50, got, bok);
    flush = 1'b1; wb_ack = 1'b1;
    run_cycles(1);
    flush = 1'b0; wb_ack = 1'b0;
    tests++;
    if (!got || busy !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL ack_flush_wb: got=%0d busy=%b wb_valid=%b expected 1/0/0", got, busy, wb_valid);
    end
    // flush alone in WB drops the writeback
    issue(MDU_MUL, 32'd5, 32'd6, 5'd9);
    wait_wb(50, got, bok);
    flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    tests++;
    if (!got || busy !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL flush_wb: got=%0d busy=%b wb_valid=%b expected 1/0/0", got, busy, wb_valid);
    end
  endtask

  task automatic test_timeout();
    bit found, wbs, got, bok;
    int ci, s0;
    never = 1'b1; s0 = err_cnt; found = 1'b0; wbs = 1'b0;
    issue(MDU_DIV, $urandom, $urandom, 5'd3);
    ci = cyc;
    for (int k = 0; k < 200; k++) begin
      if (err_timeout === 1'b1) begin found = 1'b1; break; end
      if (wb_valid !== 1'b0) wbs = 1'b1;
      run_cycles(1);
    end
    tests++;
    if (!found || wbs || cyc != ci + 1 + TIMEOUT || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_fire: found=%0d wb_seen=%0d cycle %0d expected %0d busy=%b",
                        found, wbs, cyc, ci + 1 + TIMEOUT, busy);
    end
    run_cycles(5);
    tests++;
    if (err_cnt - s0 != 1 || err_timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_once: pulses=%0d err=%b expected 1/0", err_cnt - s0, err_timeout);
    end
    never = 1'b0;
    // ready one cycle too late: watchdog fires, late ready arrives in IDLE
    lat = TIMEOUT + 1; s0 = err_cnt;
    issue(MDU_REM, $urandom, $urandom, 5'd10);
    run_cycles(TIMEOUT + 6);
    tests++;
    if (err_cnt - s0 != 1 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL timeout_late_ready: pulses=%0d busy=%b wb_valid=%b expected 1/0/0", err_cnt - s0, busy, wb_valid);
    end
    // ready exactly in the timeout cycle wins
    lat = TIMEOUT; s0 = err_cnt;
    issue(MDU_MUL, 32'd9, 32'd9, 5'd11);
    ci = cyc;
    wait_wb(TIMEOUT + 10, got, bok);
    tests++;
    if (!got || cyc != ci + TIMEOUT + 1 || wb_data !== 32'd81 || err_cnt != s0) begin
      fails++; $display("FAIL timeout_ready_wins: got=%0d cycle %0d expected %0d data=%h pulses=%0d",
                        got, cyc, ci + TIMEOUT + 1, wb_data, err_cnt - s0);
    end
    wb_ack = 1'b1;
    run_cycles(1);
    wb_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got, bok;
    logic [31:0] a, b;
    lat = 20;
    issue(MDU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
    run_cycles(10);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, mdu_start, wb_valid, busy, err_timeout} !== 5'b10000 ||
        {wb_rd, wb_data, mdu_control, mdu_operand_a, mdu_operand_b} !== '0) begin
      fails++; $display("FAIL reset_async: ctrl=%b busy=%b ctl=%h a=%h b=%h expected idle/zero",
                        {req_ready, mdu_start, wb_valid}, busy, mdu_control, mdu_operand_a, mdu_operand_b);
    end
    run_cycles(2);
    reset_n = 1'b1;
    run_cycles(1);
    lat = 34; a = $urandom; b = $urandom;
    issue(MDU_MULH, a, b, 5'd17);
    wait_wb(100, got, bok);
    tests++;
    if (!got || wb_rd !== 5'd17 || wb_data !== isa(3'd1, a, b)) begin
      fails++; $display("FAIL reset_recover: got=%0d rd=%0d data=%h expected 1/17/%h", got, wb_rd, wb_data, isa(3'd1, a, b));
    end
    wb_ack = 1'b1;
    run_cycles(1);
    wb_ack = 1'b0;
  endtask

  task automatic test_random();
    bit got, bok, wbs, rrok, stable;
    int ci, d;
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic [4:0]  rd;
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lat = $urandom_range(1, 40);
      exp = isa(op, a, b);
      issue(op, a, b, rd);
      ci = cyc;
      tests++;
      if (mdu_start !== 1'b1 || mdu_control !== op || mdu_operand_a !== a || mdu_operand_b !== b) begin
        fails++; $display("FAIL rnd_issue[%0d]: start=%b ctl=%0d a=%h b=%h expected 1/%0d/%h/%h",
                          it, mdu_start, mdu_control, mdu_operand_a, mdu_operand_b, op, a, b);
      end
      if (rd == 5'd0) begin
        wait_idle(100, got, wbs, rrok);
        tests++;
        if (!got || wbs || !rrok || cyc != ci + lat + 1) begin
          fails++; $display("FAIL rnd_rd0[%0d]: idle=%0d wb_seen=%0d cycle %0d expected %0d", it, got, wbs, cyc, ci + lat + 1);
        end
      end else begin
        wait_wb(100, got, bok);
        tests++;
        if (!got || !bok || cyc != ci + lat + 1 || wb_rd !== rd || wb_data !== exp) begin
          fails++; $display("FAIL rnd_wb[%0d]: op=%0d got=%0d cycle %0d/%0d rd=%0d/%0d data=%h expected %h",
                            it, op, got, cyc, ci + lat + 1, wb_rd, rd, wb_data, exp);
        end
        d = $urandom_range(0, 3);
        stable = 1'b1;
        repeat (d) begin
          run_cycles(1);
          if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== rd) stable = 1'b0;
        end
        wb_ack = 1'b1;
        run_cycles(1);
        wb_ack = 1'b0;
        tests++;
        if (!stable || busy !== 1'b0 || req_ready !== 1'b1) begin
          fails++; $display("FAIL rnd_ack[%0d]: stable=%0d busy=%b req_ready=%b expected 1/0/1", it, stable, busy, req_ready);
        end
      end
    end
  endtask

  task automatic test_operand_hold();
    tests++;
    if (hold_errs !== 0 || hold_checks < 100) begin
      fails++; $display("FAIL operand_hold: %0d changes in %0d busy cycles expected 0", hold_errs, hold_checks);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; wb_ack = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    test_reset();
    test_mul();
    test_div_hold();
    test_flush_drain();
    test_rd0();
    test_flush_corners();
    test_timeout();
    test_reset_mid();
    test_random();
    test_operand_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
